// File: rtl/home_inventory_event_engine.sv
// home_inventory_event_engine: per-channel hysteresis/debounce threshold event detector with saturating counts and timestamps.
// Optional sticky status/irq outputs are enabled by defining EVT_ENGINE_STICKY_IRQ_EN.
module home_inventory_event_engine #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 32,
    parameter int DEB_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic [TS_W-1:0]          ts_now,
    input  logic [NUM_CH-1:0]        evt_en,
    input  logic [DEB_W-1:0]         debounce_len,
    input  logic [NUM_CH-1:0]        count_clr,
    input  logic [NUM_CH*DATA_W-1:0] thresh_hi,
    input  logic [NUM_CH*DATA_W-1:0] thresh_lo,
    input  logic [NUM_CH*DATA_W-1:0] sample,
    output logic [NUM_CH*CNT_W-1:0]  evt_count,
    output logic [NUM_CH*TS_W-1:0]   last_delta,
    output logic [NUM_CH*TS_W-1:0]   last_ts_ch,
    output logic [TS_W-1:0]          last_ts,
    output logic [NUM_CH-1:0]        evt_pulse
`ifdef EVT_ENGINE_STICKY_IRQ_EN
    ,
    output logic [NUM_CH-1:0]        evt_status,
    input  logic [NUM_CH-1:0]        status_clr,
    output logic                     irq
`endif
);
    typedef enum logic [1:0] {BELOW, PENDING, ABOVE} state_t;
    logic [DEB_W-1:0]  deb_eff;
    logic [NUM_CH-1:0] fire;
    assign deb_eff = (debounce_len == '0) ? DEB_W'(1) : debounce_len;
    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        state_t            state, state_nx;
        logic [DEB_W-1:0]  run, run_nx;
        logic [DEB_W:0]    run_inc;
        logic [DATA_W-1:0] s, hi, lo;
        logic              ge_hi, fire_c, seen, en_prev, en_pend, rise_take, pulse;
        logic [CNT_W-1:0]  cnt;
        logic [TS_W-1:0]   delta, lts;
        assign s         = sample[i*DATA_W +: DATA_W];
        assign hi        = thresh_hi[i*DATA_W +: DATA_W];
        assign lo        = thresh_lo[i*DATA_W +: DATA_W];
        assign ge_hi     = s >= hi;
        assign run_inc   = {1'b0, run} + (DEB_W+1)'(1);
        // A rise seen this cycle or held from an earlier idle cycle is consumed by the next sample
        assign rise_take = sample_valid & evt_en[i] & (en_pend | ~en_prev);
        always_comb begin
            state_nx = state;
            run_nx   = run;
            fire_c   = 1'b0;
            if (!evt_en[i]) begin
                state_nx = BELOW;
                run_nx   = '0;
            end else if (sample_valid) begin
                case (state)
                    BELOW: if (ge_hi) begin
                        fire_c   = deb_eff == DEB_W'(1);
                        state_nx = fire_c ? ABOVE : PENDING;
                        run_nx   = fire_c ? '0 : DEB_W'(1);
                    end
                    PENDING: begin
                        fire_c   = ge_hi && run_inc >= {1'b0, deb_eff};
                        state_nx = !ge_hi ? BELOW : fire_c ? ABOVE : PENDING;
                        run_nx   = (ge_hi && !fire_c) ? run_inc[DEB_W-1:0] : '0;
                    end
                    ABOVE: state_nx = (s < lo) ? BELOW : ABOVE;
                    default: state_nx = BELOW;
                endcase
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= BELOW;
                run     <= '0;
                seen    <= 1'b0;
                en_prev <= 1'b0;
                en_pend <= 1'b0;
                pulse   <= 1'b0;
                cnt     <= '0;
                delta   <= '0;
                lts     <= '0;
            end else begin
                state   <= state_nx;
                run     <= run_nx;
                en_prev <= evt_en[i];
                en_pend <= evt_en[i] & (en_pend | ~en_prev) & ~sample_valid;
                pulse   <= fire_c;
                cnt     <= count_clr[i] ? CNT_W'(fire_c) : (fire_c && cnt != '1) ? cnt + CNT_W'(1) : cnt;
                if (rise_take) begin
                    seen  <= 1'b0;
                    lts   <= '0;
                    delta <= '0;
                end
                if (fire_c) begin
                    delta <= (seen && !rise_take) ? ts_now - lts : '0;
                    lts   <= ts_now;
                    seen  <= 1'b1;
                end
            end
        end
        assign fire[i]                    = fire_c;
        assign evt_pulse[i]               = pulse;
        assign evt_count[i*CNT_W +: CNT_W] = cnt;
        assign last_delta[i*TS_W +: TS_W] = delta;
        assign last_ts_ch[i*TS_W +: TS_W] = lts;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_ts <= '0;
        else if (|fire) last_ts <= ts_now;
    end
`ifdef EVT_ENGINE_STICKY_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) evt_status <= '0;
        else evt_status <= (evt_status & ~status_clr) | fire;
    end
    assign irq = |(evt_status & evt_en);
`endif
endmodule
